st_unit: RTL
============

Name: st_unit

Overview:
- Store-side counterpart of the load address path.
- Accepts SB/SH/SW from execute and computes the effective address rs1 + sext(offset).
- Forms byte enables and lane-replicated write data, buffers the stores in a small FIFO, and drains them to data memory over a req/ack handshake.
- Flags misaligned or illegal stores and reports load/store address conflicts so loads can stall.

Parameters:
- DEPTH, 2, store buffer entries (power of two, >=2)
- AW, 32, address width
- DW, 32, data width (fixed 32; byte lanes = 4)

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- store_en_i  in  1  store request from execute, valid this cycle
- offset_i  in  12  S-type immediate, sign-extended internally
- funct3_i  in  3  store width: 000 SB, 001 SH, 010 SW
- rs1_data_i  in  32  base address
- rs2_data_i  in  32  store data
- st_ready_o  out  1  buffer can accept a store (high when not full)
- st_empty_o  out  1  no pending stores (fence/drain indication)
- st_fault_o  out  1  one-cycle pulse: misaligned or illegal funct3
- st_fault_addr_o  out  32  effective address of the last faulting store
- ld_addr_i  in  32  pending load address
- ld_conflict_o  out  1  ld_addr_i word matches any valid buffered entry
- mem_req_o  out  1  write request to data memory
- mem_addr_o  out  32  word-aligned address {ea[31:2],2'b00}
- mem_wdata_o  out  32  lane-aligned write data
- mem_be_o  out  4  byte enables
- mem_ack_i  in  1  memory accepted the current request

Behaviour:
- Reset values (asynchronous, on rst_n_i low): FIFO empty, st_ready_o=1, st_empty_o=1, st_fault_o=0, st_fault_addr_o=0, mem_req_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0.
  - A reset mid-transaction drops mem_req_o immediately and discards all buffered stores.
- Accept: store_en_i && st_ready_o in cycle N.
  - ea = rs1_data_i + {{20{offset_i[11]}},offset_i}, modulo 2^32 (wraps; no carry out).
  - store_en_i while st_ready_o=0 is ignored; the pipeline must hold the request.
- Encoding, legal funct3 only:
  - SB: be = 4'b0001 << ea[1:0]; wdata = {4{rs2[7:0]}}.
  - SH: be = 4'b0011 << {ea[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - SW: be = 4'b1111; wdata = rs2.
- Faults:
  - Faulting cases: SH with ea[0]=1, SW with ea[1:0]!=0, or funct3 not in {000,001,010}.
  - A faulting store is not enqueued.
  - st_fault_o pulses in cycle N+1 and st_fault_addr_o <= ea; st_fault_addr_o holds until the next fault.
- Issue FSM, two states:
  - IDLE: mem_req_o=0. Moves to REQ when the FIFO is non-empty at a clock edge.
  - REQ: mem_req_o=1 with addr/wdata/be taken from the FIFO head. All of these stay stable until mem_ack_i.
  - On mem_ack_i in REQ, the head is popped. The FSM stays in REQ if another entry remains, otherwise returns to IDLE.
- Latency: a store accepted into an empty buffer at edge N drives mem_req_o from cycle N+1. A zero-wait-state ack in that cycle retires it, giving 1 cycle accept-to-issue.
- FIFO ordering and boundaries:
  - Strict FIFO order.
  - A push and a pop in the same cycle leave the count unchanged.
  - When full, st_ready_o=0 even if mem_ack_i is high that cycle (no same-cycle pass-through).
  - Read/write pointers wrap modulo DEPTH; an extra pointer bit distinguishes full from empty.
- mem_ack_i while mem_req_o=0 is ignored.
- st_empty_o = (count==0), registered state only.
- ld_conflict_o: combinational. High if any valid entry has addr[31:2]==ld_addr_i[31:2], including the head being issued. It does not include a store being accepted this cycle.

Decomposition:
- Package y_risc_pkg:
  - Constants F3_SB=3'b000, F3_SH=3'b001, F3_SW=3'b010.
  - Typedef st_entry_t {addr[31:2], wdata[31:0], be[3:0]}.
  - FSM state enum {ST_IDLE, ST_REQ}.
- One sub-module, st_fifo: parameterised DEPTH, synchronous push/pop, async reset, with full/empty/count outputs and an entry array view for the conflict compare.

Test Plan:
- SW, rs1=0x1000, off=0x004, rs2=0xDEADBEEF, ack tied high -> next cycle mem_req_o=1, addr=0x1004, be=1111, wdata=0xDEADBEEF; st_empty_o=1 after ack.
- SB, rs1=0x2003, off=0xFFF (-1), rs2=0x000000AB -> ea=0x2002, addr=0x2000, be=0100, wdata=0xABABABAB.
- SH, ea=0x3001 -> st_fault_o pulses one cycle, st_fault_addr_o=0x3001, no mem_req_o. funct3=3'b011 -> fault, nothing enqueued.
- ack held low, three back-to-back SW -> two accepted, st_ready_o=0 on third. Release ack -> stores issue in order, and mem_addr/wdata/be stay stable while waiting.
- Entry 0x4000 pending with ld_addr_i=0x4002 -> ld_conflict_o=1. With ld_addr_i=0x4004 -> 0. After the entry retires -> 0.
- rst_n_i low while mem_req_o=1 with 2 entries -> mem_req_o=0 immediately, st_empty_o=1, and no request after reset release.

Source files
------------

// File: rtl/y_risc_pkg.sv
// Shared store-path types: funct3 width codes, buffered store entry, issue FSM states.
// Also holds the alignment rule used to reject misaligned or unknown-width stores.
package y_risc_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef struct packed {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } st_entry_t;

    typedef enum logic {
        ST_IDLE,
        ST_REQ
    } st_state_e;

    // Unknown widths are treated as faulting so they can never reach memory.
    function automatic logic st_bad_store(input logic [2:0] f3, input logic [1:0] lo);
        logic bad;
        case (f3)
            F3_SB:   bad = 1'b0;
            F3_SH:   bad = lo[0];
            F3_SW:   bad = |lo;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/st_fifo.sv
// Store buffer: DEPTH-entry FIFO with wrap-bit pointers, plus a per-entry valid view
// so the owner can compare pending store addresses against a load.
module st_fifo
    import y_risc_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_i,
    input  st_entry_t  push_data_i,
    input  logic       pop_i,
    output st_entry_t  head_o,
    output logic       full_o,
    output logic       empty_o,
    output logic [PW:0] count_o,
    output st_entry_t  entries_o [DEPTH],
    output logic [DEPTH-1:0] valid_o
);

    st_entry_t   mem_q [DEPTH];
    st_entry_t   mem_d [DEPTH];
    logic [PW:0] wr_ptr_q, wr_ptr_d;
    logic [PW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push;
    logic        do_pop;
    logic [PW-1:0] rel;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign head_o    = mem_q[rd_ptr_q[PW-1:0]];
    assign entries_o = mem_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = push_data_i;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        valid_o = '0;
        rel     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel        = PW'(i) - rd_ptr_q[PW-1:0];
            valid_o[i] = ({1'b0, rel} < count_o);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/st_unit.sv
// Store unit: effective address, byte-enable/lane formatting, fault detection,
// store buffering and in-order drain to data memory over req/ack.
module st_unit
    import y_risc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          store_en_i,
    input  logic [11:0]   offset_i,
    input  logic [2:0]    funct3_i,
    input  logic [AW-1:0] rs1_data_i,
    input  logic [DW-1:0] rs2_data_i,
    output logic          st_ready_o,
    output logic          st_empty_o,
    output logic          st_fault_o,
    output logic [AW-1:0] st_fault_addr_o,
    input  logic [AW-1:0] ld_addr_i,
    output logic          ld_conflict_o,
    output logic          mem_req_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [3:0]    mem_be_o,
    input  logic          mem_ack_i
);

    localparam int PW = $clog2(DEPTH);

    // Handshake: the memory side sees mem_req_o with stable addr/wdata/be; a cycle
    // with mem_req_o && mem_ack_i retires the head. Ack without req has no effect.
    st_state_e     state_q, state_d;
    logic          fault_q, fault_d;
    logic [AW-1:0] fault_addr_q, fault_addr_d;

    logic [AW-1:0] ea;
    logic          accept;
    logic          bad;
    logic          push;
    logic          pop;
    st_entry_t     new_entry;
    st_entry_t     head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [PW:0]   fifo_count;
    st_entry_t     fifo_entries [DEPTH];
    logic [DEPTH-1:0] fifo_valid;
    logic          conflict;
    logic          unused_ld_lo;

    assign ea     = rs1_data_i + {{(AW-12){offset_i[11]}}, offset_i};
    assign accept = store_en_i && !fifo_full;
    assign bad    = st_bad_store(funct3_i, ea[1:0]);
    assign push   = accept && !bad;
    assign pop    = (state_q == ST_REQ) && mem_ack_i;

    always_comb begin
        new_entry      = '0;
        new_entry.addr = ea[AW-1:2];
        case (funct3_i)
            F3_SB: begin
                new_entry.be    = 4'b0001 << ea[1:0];
                new_entry.wdata = {4{rs2_data_i[7:0]}};
            end
            F3_SH: begin
                new_entry.be    = 4'b0011 << {ea[1], 1'b0};
                new_entry.wdata = {2{rs2_data_i[15:0]}};
            end
            default: begin
                new_entry.be    = 4'b1111;
                new_entry.wdata = rs2_data_i;
            end
        endcase
    end

    st_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (push),
        .push_data_i (new_entry),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .entries_o   (fifo_entries),
        .valid_o     (fifo_valid)
    );

    // A push into an empty buffer raises the request on the same edge, so the
    // store is on the bus the cycle after it was accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (push || !fifo_empty) state_d = ST_REQ;
            ST_REQ:  if (pop && !push && fifo_count == (PW+1)'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fault_d      = accept && bad;
        fault_addr_d = (accept && bad) ? ea : fault_addr_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid[i] && fifo_entries[i].addr == ld_addr_i[AW-1:2]) begin
                conflict = 1'b1;
            end
        end
    end

    assign unused_ld_lo = ^ld_addr_i[1:0];

    assign st_ready_o      = !fifo_full;
    assign st_empty_o      = fifo_empty;
    assign st_fault_o      = fault_q;
    assign st_fault_addr_o = fault_addr_q;
    assign ld_conflict_o   = conflict;
    assign mem_req_o       = (state_q == ST_REQ);
    assign mem_addr_o      = mem_req_o ? {head.addr, 2'b00} : '0;
    assign mem_wdata_o     = mem_req_o ? head.wdata : '0;
    assign mem_be_o        = mem_req_o ? head.be : 4'b0000;

endmodule
